rv32i_lsu_ctrl: RTL and testbench

RV32I_LSU_CTRL -- requirements
Module: rv32i_lsu_ctrl

---
 rtl/rv32i_lsu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rv32i_lsu_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu_ctrl.sv
// rv32i_lsu_ctrl: RV32I load/store controller turning decoded requests into word-aligned
// memory transactions with load extension, exception reporting and a response timeout.
module rv32i_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_imm,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rsp_err,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done_valid,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] ea_q, ea_d, wd_q, wd_d;
    logic [2:0] f3_q, f3_d;
    logic [4:0] rd_q, rd_d;
    logic [3:0] cause_q, cause_d;
    logic store_q, store_d, exc_q, exc_d;
    logic req_ready_q, busy_q, mem_req_valid_q, mem_we_q, wb_valid_q, done_valid_q, exc_valid_q;
    logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q, exc_addr_q;
    logic [3:0] mem_be_q, exc_cause_q;
    logic [4:0] wb_rd_q;
    logic [31:0] req_ea, ld_d, ld_ext, st_data;
    logic is_ld, is_st, legal, misal, issue_n, resp_n, wb_n;
    logic [3:0] be_n;
    assign req_ea  = req_base + {{20{req_imm[11]}}, req_imm};
    assign is_ld   = req_opcode == 7'b0000011;
    assign is_st   = req_opcode == 7'b0100011;
    assign legal   = (is_ld && (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                  || (is_st && (req_funct3 inside {3'b000, 3'b001, 3'b010}));
    assign misal   = (req_funct3[1:0] == 2'b01 && req_ea[0]) || (req_funct3[1:0] == 2'b10 && req_ea[1:0] != 2'b00);
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ea_d    = ea_q;
        wd_d    = wd_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        store_d = store_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                ea_d    = req_ea;
                wd_d    = req_wdata;
                f3_d    = req_funct3;
                rd_d    = req_rd;
                store_d = is_st;
                exc_d   = !legal || misal;
                cause_d = !legal ? 4'd2 : is_st ? 4'd6 : 4'd4;
                state_d = exc_d ? RESP : ISSUE;
            end
            ISSUE: state_d = mem_req_ready ? WAIT : ISSUE;
            WAIT: if (mem_rsp_valid) begin
                state_d = RESP;
                exc_d   = mem_rsp_err;
                cause_d = store_q ? 4'd7 : 4'd5;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                state_d = RESP;
                exc_d   = 1'b1;
                cause_d = store_q ? 4'd7 : 4'd5;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from next-state values so they line up with the state they describe.
    assign issue_n = state_d == ISSUE;
    assign resp_n  = state_d == RESP;
    assign wb_n    = resp_n && !exc_d && !store_d && rd_d != 5'd0;
    assign be_n    = f3_d[1:0] == 2'b00 ? 4'b0001 << ea_d[1:0] : f3_d[1:0] == 2'b01 ? 4'b0011 << ea_d[1:0] : 4'b1111;
    assign st_data = f3_d[1:0] == 2'b00 ? {4{wd_d[7:0]}} : f3_d[1:0] == 2'b01 ? {2{wd_d[15:0]}} : wd_d;
    assign ld_d    = mem_rdata >> {ea_d[1:0], 3'b000};
    assign ld_ext  = f3_d == 3'b000 ? {{24{ld_d[7]}}, ld_d[7:0]}
                   : f3_d == 3'b100 ? {24'd0, ld_d[7:0]}
                   : f3_d == 3'b001 ? {{16{ld_d[15]}}, ld_d[15:0]}
                   : f3_d == 3'b101 ? {16'd0, ld_d[15:0]} : ld_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            ea_q            <= '0;
            wd_q            <= '0;
            f3_q            <= '0;
            rd_q            <= '0;
            store_q         <= 1'b0;
            exc_q           <= 1'b0;
            cause_q         <= '0;
            req_ready_q     <= 1'b0;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_be_q        <= '0;
            mem_wdata_q     <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            done_valid_q    <= 1'b0;
            exc_valid_q     <= 1'b0;
            exc_cause_q     <= '0;
            exc_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ea_q            <= ea_d;
            wd_q            <= wd_d;
            f3_q            <= f3_d;
            rd_q            <= rd_d;
            store_q         <= store_d;
            exc_q           <= exc_d;
            cause_q         <= cause_d;
            req_ready_q     <= state_d == IDLE;
            busy_q          <= state_d != IDLE;
            mem_req_valid_q <= issue_n;
            mem_addr_q      <= issue_n ? {ea_d[31:2], 2'b00} : 32'd0;
            mem_we_q        <= issue_n && store_d;
            mem_be_q        <= issue_n ? be_n : 4'd0;
            mem_wdata_q     <= issue_n && store_d ? st_data : 32'd0;
            wb_valid_q      <= wb_n;
            wb_rd_q         <= wb_n ? rd_d : 5'd0;
            wb_data_q       <= wb_n ? ld_ext : 32'd0;
            done_valid_q    <= resp_n;
            exc_valid_q     <= resp_n && exc_d;
            exc_cause_q     <= resp_n && exc_d ? cause_d : 4'd0;
            exc_addr_q      <= resp_n && exc_d ? ea_d : 32'd0;
        end
    end
    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign done_valid    = done_valid_q;
    assign exc_valid     = exc_valid_q;
    assign exc_cause     = exc_cause_q;
    assign exc_addr      = exc_addr_q;
endmodule

// File: tb/tb_rv32i_lsu_ctrl.sv
// tb_rv32i_lsu_ctrl: directed self-checking bench for rv32i_lsu_ctrl with a 4-cycle timeout.
module tb_rv32i_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_base = '0;
    logic [11:0] req_imm = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rsp_err = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done_valid;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        busy;
    int passed = 0;
    int total = 0;

    rv32i_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode), .req_funct3(req_funct3),
        .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .mem_rsp_err(mem_rsp_err), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done_valid(done_valid), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] base,
                       input logic [11:0] imm, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1;
        req_opcode = op;
        req_funct3 = f3;
        req_base = base;
        req_imm = imm;
        req_wdata = wd;
        req_rd = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic accept_issue;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        mem_rsp_valid = 1'b1;
        mem_rdata = rdata;
        mem_rsp_err = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_done", 32'(done_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // LB 0x1000-1 -> byte lane 3
        req(7'b0000011, 3'b000, 32'h1000, 12'hFFF, 32'd0, 5'd5);
        chk("lb_mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("lb_mem_addr", mem_addr, 32'h0000_0FFC);
        chk("lb_be", 32'(mem_be), 32'b1000);
        chk("lb_we", 32'(mem_we), 32'd0);
        chk("lb_req_ready", 32'(req_ready), 32'd0);
        chk("lb_busy", 32'(busy), 32'd1);
        accept_issue();
        chk("lb_wait_no_req", 32'(mem_req_valid), 32'd0);
        respond(32'h80FF_0000, 1'b0);
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);
        chk("lb_wb_rd", 32'(wb_rd), 32'd5);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_done", 32'(done_valid), 32'd1);
        chk("lb_no_exc", 32'(exc_valid), 32'd0);
        tick();
        chk("lb_done_pulse", 32'(done_valid), 32'd0);
        chk("lb_wb_data_zero", wb_data, 32'd0);
        chk("lb_back_idle", 32'(req_ready), 32'd1);

        // SH to 0x2002
        req(7'b0100011, 3'b001, 32'h2002, 12'h000, 32'h1234_ABCD, 5'd0);
        chk("sh_be", 32'(mem_be), 32'b1100);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(mem_we), 32'd1);
        chk("sh_addr", mem_addr, 32'h0000_2000);
        accept_issue();
        respond(32'd0, 1'b0);
        chk("sh_done", 32'(done_valid), 32'd1);
        chk("sh_no_wb", 32'(wb_valid), 32'd0);
        chk("sh_no_exc", 32'(exc_valid), 32'd0);
        tick();

        // Misaligned LW at 0x3001
        req(7'b0000011, 3'b010, 32'h3000, 12'h001, 32'd0, 5'd7);
        chk("lw_mis_exc", 32'(exc_valid), 32'd1);
        chk("lw_mis_cause", 32'(exc_cause), 32'd4);
        chk("lw_mis_addr", exc_addr, 32'h0000_3001);
        chk("lw_mis_no_mem", 32'(mem_req_valid), 32'd0);
        chk("lw_mis_done", 32'(done_valid), 32'd1);
        chk("lw_mis_no_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("lw_mis_exc_clear", 32'(exc_valid), 32'd0);
        chk("lw_mis_cause_zero", 32'(exc_cause), 32'd0);
        chk("lw_mis_addr_zero", exc_addr, 32'd0);

        // SW held 5 cycles, then bus error
        req(7'b0100011, 3'b010, 32'h4000, 12'h008, 32'hDEAD_BEEF, 5'd0);
        for (int i = 0; i < 5; i++) begin
            chk("sw_hold_valid", 32'(mem_req_valid), 32'd1);
            chk("sw_hold_addr", mem_addr, 32'h0000_4008);
            chk("sw_hold_be", 32'(mem_be), 32'hF);
            chk("sw_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            if (i < 4) tick();
        end
        accept_issue();
        respond(32'd0, 1'b1);
        chk("sw_err_exc", 32'(exc_valid), 32'd1);
        chk("sw_err_cause", 32'(exc_cause), 32'd7);
        chk("sw_err_addr", exc_addr, 32'h0000_4008);
        tick();

        // LW timeout with TIMEOUT_CYCLES=4
        req(7'b0000011, 3'b010, 32'h5000, 12'h000, 32'd0, 5'd3);
        accept_issue();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_waiting", 32'(exc_valid), 32'd0);
        end
        chk("to_busy", 32'(busy), 32'd1);
        tick();
        chk("to_exc", 32'(exc_valid), 32'd1);
        chk("to_cause", 32'(exc_cause), 32'd5);
        chk("to_no_wb", 32'(wb_valid), 32'd0);
        tick();

        // LHU zero-extend
        req(7'b0000011, 3'b101, 32'h6000, 12'h000, 32'd0, 5'd9);
        chk("lhu_be", 32'(mem_be), 32'b0011);
        accept_issue();
        respond(32'hFFFF_8001, 1'b0);
        chk("lhu_wb_valid", 32'(wb_valid), 32'd1);
        chk("lhu_wb_data", wb_data, 32'h0000_8001);
        tick();

        // LH upper half sign-extend
        req(7'b0000011, 3'b001, 32'h6000, 12'h002, 32'd0, 5'd10);
        accept_issue();
        respond(32'h8001_1234, 1'b0);
        chk("lh_wb_data", wb_data, 32'hFFFF_8001);
        tick();

        // Illegal funct3 store
        req(7'b0100011, 3'b100, 32'h7000, 12'h000, 32'd0, 5'd0);
        chk("ill_exc", 32'(exc_valid), 32'd1);
        chk("ill_cause", 32'(exc_cause), 32'd2);
        chk("ill_no_mem", 32'(mem_req_valid), 32'd0);
        tick();

        // Misaligned SH store
        req(7'b0100011, 3'b001, 32'h7001, 12'h000, 32'd0, 5'd0);
        chk("sh_mis_cause", 32'(exc_cause), 32'd6);
        tick();

        // LW to x0: done but no writeback
        req(7'b0000011, 3'b010, 32'h7000, 12'h000, 32'd0, 5'd0);
        accept_issue();
        respond(32'h1234_5678, 1'b0);
        chk("x0_done", 32'(done_valid), 32'd1);
        chk("x0_no_wb", 32'(wb_valid), 32'd0);
        chk("x0_wb_data_zero", wb_data, 32'd0);
        tick();

        // Reset during WAIT, stale response afterwards
        req(7'b0000011, 3'b010, 32'h8000, 12'h000, 32'd0, 5'd4);
        accept_issue();
        rst_n = 1'b0;
        #2;
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_req_ready", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("rstw_no_wb", 32'(wb_valid), 32'd0);
        chk("rstw_no_done", 32'(done_valid), 32'd0);
        chk("rstw_no_exc", 32'(exc_valid), 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstw_no_done2", 32'(done_valid), 32'd0);
        chk("rstw_req_ready_idle", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
